// File: rtl/note_event_buffer_if.sv
// ---------------------------------------------------------------------------
// note_event_buffer_if
//
// Purpose: valid/ready event stream leaving the note event buffer toward the
//          score/display or UART stage.
//
// Signals:
//   event_valid  producer -> consumer  head event present
//   event_data   producer -> consumer  10-bit head event
//   event_ready  consumer -> producer  consumer takes the head event this cycle
//
// Modports: master = the buffer (producer), slave = the consumer.
// ---------------------------------------------------------------------------
interface note_event_buffer_if;
    logic       event_valid;
    logic [9:0] event_data;
    logic       event_ready;

    modport master (
        output event_valid,
        output event_data,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_data,
        output event_ready
    );
endinterface

// File: rtl/note_event_buffer.sv
// ---------------------------------------------------------------------------
// note_event_buffer
//
// Purpose: packs each classified note/rest from the duration detector into a
//          10-bit event, optionally inserts bar-line marker events at measure
//          boundaries, and buffers the events in a first-word-fall-through
//          circular FIFO.
//
// Event formats:
//   note   : [9]=0, [8]=rest, [7:6]=duration (0 eighth .. 3 whole), [5:0]=tone
//   marker : [9]=1, [8]=0,    [7:0]=index of the measure just completed
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   new_note_ready           one-cycle strobe qualifying tone + flags
//   new_note_tone[5:0]       tone index (0 = silence)
//   eighth/quarter/half/whole_note, *_rest   one-hot duration flags
//   evt (master)             event stream: event_valid/event_data/event_ready
//   fill_level               entries stored
//   overflow                 sticky: a valid group was lost to a full FIFO
//   dropped_count            saturating count of discarded strobes
//   measure_count            completed measures (wraps at 256)
//
// Build option: define MEASURE_MARKER_EN to enable bar-marker insertion and
// measure accounting. Without it every valid group is a single note event and
// measure_count is tied to 0.
// ---------------------------------------------------------------------------
module note_event_buffer #(
    parameter int DEPTH               = 32,
    parameter int EIGHTHS_PER_MEASURE = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     new_note_ready,
    input  logic [5:0]               new_note_tone,
    input  logic                     eighth_note,
    input  logic                     quarter_note,
    input  logic                     half_note,
    input  logic                     whole_note,
    input  logic                     eighth_rest,
    input  logic                     quarter_rest,
    input  logic                     half_rest,
    input  logic                     whole_rest,
    note_event_buffer_if.master      evt,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [7:0]               dropped_count,
    output logic [7:0]               measure_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("note_event_buffer: DEPTH must be a power of 2, at least 4");
        end
        if (EIGHTHS_PER_MEASURE < 2 || EIGHTHS_PER_MEASURE > 255) begin : g_bad_epm
            $error("note_event_buffer: EIGHTHS_PER_MEASURE must be 2..255");
        end
    endgenerate

    // Storage and FIFO state
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    dropped_q, dropped_d;

    // Input decode
    logic [7:0]    flags;
    logic          flag_ok;
    logic          is_rest;
    logic [1:0]    dur_code;
    logic [9:0]    note_word;
    logic          need_marker;
    logic          fifo_valid;
    logic          pop;
    logic [FW:0]   free_slots;
    logic [FW:0]   need_slots;
    logic          fits;
    logic          accept;
    logic [1:0]    push_count;

    assign flags = {whole_rest, half_rest, quarter_rest, eighth_rest,
                    whole_note, half_note, quarter_note, eighth_note};

    // Exactly one flag set: non-zero and clearing the lowest set bit leaves 0.
    assign flag_ok  = (flags != 8'd0) && ((flags & (flags - 8'd1)) == 8'd0);
    assign is_rest  = |flags[7:4];
    assign dur_code = {flags[7] | flags[6] | flags[3] | flags[2],
                       flags[7] | flags[5] | flags[3] | flags[1]};
    assign note_word = {1'b0, is_rest, dur_code, new_note_tone};

    assign fifo_valid = (fill_q != '0);
    assign pop        = fifo_valid & evt.event_ready;

    // A pop in the same cycle frees a slot for this cycle's write, so a
    // full FIFO being drained can still take a single-entry group.
    assign free_slots = (FW+1)'(DEPTH) - {1'b0, fill_q} + {{FW{1'b0}}, pop};
    assign need_slots = need_marker ? (FW+1)'(2) : (FW+1)'(1);
    assign fits       = (need_slots <= free_slots);

    // The note and its marker are accepted or dropped as one group.
    assign accept     = new_note_ready & flag_ok & fits;
    assign push_count = accept ? (need_marker ? 2'd2 : 2'd1) : 2'd0;

`ifdef MEASURE_MARKER_EN
    logic [7:0] acc_q, acc_d;
    logic [7:0] meas_q, meas_d;
    logic [3:0] note_len;
    logic [8:0] acc_sum;
    logic [9:0] marker_word;

    assign note_len    = 4'd1 << dur_code;
    assign acc_sum     = {1'b0, acc_q} + {5'd0, note_len};
    assign need_marker = (acc_sum >= 9'(EIGHTHS_PER_MEASURE));
    // Marker carries the index of the measure that this note completes.
    assign marker_word = {2'b10, meas_q};

    // A note crossing the barline is not split; its overshoot carries over.
    always_comb begin
        acc_d  = acc_q;
        meas_d = meas_q;
        if (accept) begin
            if (need_marker) begin
                acc_d  = 8'(acc_sum - 9'(EIGHTHS_PER_MEASURE));
                meas_d = meas_q + 8'd1;
            end else begin
                acc_d  = acc_sum[7:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            acc_q  <= 8'd0;
            meas_q <= 8'd0;
        end else begin
            acc_q  <= acc_d;
            meas_q <= meas_d;
        end
    end

    assign measure_count = meas_q;
`else
    assign need_marker   = 1'b0;
    assign measure_count = 8'd0;
`endif

    // Storage write: note in the lower slot, marker in the following slot.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= note_word;
`ifdef MEASURE_MARKER_EN
            if (need_marker) begin
                mem_q[wr_ptr_q + AW'(1)] <= marker_word;
            end
`endif
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push_count);
        fill_d     = fill_q + FW'(push_count) - FW'(pop);
        overflow_d = overflow_q | (new_note_ready & flag_ok & ~fits);
        dropped_d  = dropped_q;
        if (new_note_ready && !accept && dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 8'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // First-word fall-through: head entry is visible straight from storage;
    // forced to zero while empty so stale entries never leak out.
    assign evt.event_valid = fifo_valid;
    assign evt.event_data  = fifo_valid ? mem_q[rd_ptr_q] : 10'd0;

    assign fill_level    = fill_q;
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_note_event_buffer.sv
// ---------------------------------------------------------------------------
// tb_note_event_buffer
//
// Directed testbench for note_event_buffer (DEPTH=32, 4/4 measures).
// Expected values depend on whether MEASURE_MARKER_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_note_event_buffer;

`ifdef MEASURE_MARKER_EN
    localparam bit MK = 1'b1;
`else
    localparam bit MK = 1'b0;
`endif

    // Flag bit positions used by the bench
    localparam logic [7:0] F_EN = 8'h01, F_QN = 8'h02, F_HN = 8'h04, F_WN = 8'h08;
    localparam logic [7:0] F_ER = 8'h10, F_QR = 8'h20, F_HR = 8'h40, F_WR = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       nnr = 1'b0;
    logic [5:0] tone = 6'd0;
    logic [7:0] flags = 8'd0;
    logic [5:0] fill_level;
    logic       overflow;
    logic [7:0] dropped_count;
    logic [7:0] measure_count;

    int n_checks = 0;
    int n_errors = 0;

    note_event_buffer_if evt_if ();

    note_event_buffer #(
        .DEPTH               (32),
        .EIGHTHS_PER_MEASURE (8)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .new_note_ready (nnr),
        .new_note_tone  (tone),
        .eighth_note    (flags[0]),
        .quarter_note   (flags[1]),
        .half_note      (flags[2]),
        .whole_note     (flags[3]),
        .eighth_rest    (flags[4]),
        .quarter_rest   (flags[5]),
        .half_rest      (flags[6]),
        .whole_rest     (flags[7]),
        .evt            (evt_if.master),
        .fill_level     (fill_level),
        .overflow       (overflow),
        .dropped_count  (dropped_count),
        .measure_count  (measure_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] tone;
        logic [7:0] flags;
        logic       exp_valid;
        logic [9:0] exp_data;
        int         exp_fill;
        int         exp_drop;
    } vec_t;

    vec_t vecs[10];
    logic [9:0] expq[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            $display("ok   %s: 0x%0h", name, actual);
        end
    endtask

    // All stimulus changes and samples happen on the falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        evt_if.event_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [5:0] t, input logic [7:0] f);
        @(negedge clk);
        nnr   = 1'b1;
        tone  = t;
        flags = f;
        @(negedge clk);
        nnr   = 1'b0;
        flags = 8'd0;
        tone  = 6'd0;
    endtask

    task automatic pop_check(input string name, input logic [9:0] exp);
        check({name, ".valid"}, 32'(evt_if.event_valid), 32'd1);
        check({name, ".data"}, 32'(evt_if.event_data), 32'(exp));
        evt_if.event_ready = 1'b1;
        @(negedge clk);
        evt_if.event_ready = 1'b0;
    endtask

    task automatic drain_expected(input string name);
        int k;
        k = 0;
        while (expq.size() > 0) begin
            pop_check($sformatf("%s[%0d]", name, k), expq.pop_front());
            k++;
        end
        check({name, ".empty"}, 32'(evt_if.event_valid), 32'd0);
    endtask

    initial begin
        evt_if.event_ready = 1'b0;

        vecs[0] = '{"quarter_t12",   6'd12, F_QN, 1'b1, 10'h04C, 1, 0};
        vecs[1] = '{"eighth_t5",     6'd5,  F_EN, 1'b1, 10'h005, 1, 0};
        vecs[2] = '{"half_t9",       6'd9,  F_HN, 1'b1, 10'h089, 1, 0};
        vecs[3] = '{"whole_t1",      6'd1,  F_WN, 1'b1, 10'h0C1, MK ? 2 : 1, 0};
        vecs[4] = '{"eighth_rest",   6'd0,  F_ER, 1'b1, 10'h100, 1, 0};
        vecs[5] = '{"quarter_rest",  6'd0,  F_QR, 1'b1, 10'h140, 1, 0};
        vecs[6] = '{"half_rest_t63", 6'd63, F_HR, 1'b1, 10'h1BF, 1, 0};
        vecs[7] = '{"whole_rest",    6'd0,  F_WR, 1'b1, 10'h1C0, MK ? 2 : 1, 0};
        vecs[8] = '{"no_flags",      6'd12, 8'h00, 1'b0, 10'h000, 0, 1};
        vecs[9] = '{"two_flags",     6'd12, F_QN | F_HN, 1'b0, 10'h000, 0, 1};

        // Reset state
        do_reset();
        check("rst.valid",    32'(evt_if.event_valid), 32'd0);
        check("rst.data",     32'(evt_if.event_data),  32'd0);
        check("rst.fill",     32'(fill_level),         32'd0);
        check("rst.overflow", 32'(overflow),           32'd0);
        check("rst.dropped",  32'(dropped_count),      32'd0);
        check("rst.measure",  32'(measure_count),      32'd0);

        // Encoding table: one group into an empty, freshly reset FIFO
        for (int i = 0; i < 10; i++) begin
            do_reset();
            send(vecs[i].tone, vecs[i].flags);
            check({vecs[i].name, ".valid"},   32'(evt_if.event_valid), 32'(vecs[i].exp_valid));
            check({vecs[i].name, ".data"},    32'(evt_if.event_data),  32'(vecs[i].exp_data));
            check({vecs[i].name, ".fill"},    32'(fill_level),         32'(vecs[i].exp_fill));
            check({vecs[i].name, ".dropped"}, 32'(dropped_count),      32'(vecs[i].exp_drop));
        end

        // Single quarter then one pop empties the FIFO
        do_reset();
        send(6'd12, F_QN);
        pop_check("q12.pop", 10'h04C);
        check("q12.after_pop.valid", 32'(evt_if.event_valid), 32'd0);
        check("q12.after_pop.fill",  32'(fill_level),         32'd0);

        // One full measure: 1+1+2+4 eighths ends exactly on the barline
        do_reset();
        send(6'd5, F_EN);
        send(6'd5, F_EN);
        send(6'd7, F_QN);
        send(6'd9, F_HN);
        check("meas1.fill",    32'(fill_level),    MK ? 32'd5 : 32'd4);
        check("meas1.measure", 32'(measure_count), MK ? 32'd1 : 32'd0);
        expq = '{10'h005, 10'h005, 10'h047, 10'h089};
        if (MK) expq.push_back(10'h200);
        drain_expected("meas1");

        // Crossing the barline: 3 + 8 = 11 -> marker, carry 3; then 3+2+2+1 = 8
        do_reset();
        for (int i = 0; i < 3; i++) send(6'd0, F_ER);
        send(6'd0, F_WR);
        send(6'd2, F_QN);
        send(6'd2, F_QN);
        check("carry.measure_mid", 32'(measure_count), MK ? 32'd1 : 32'd0);
        send(6'd2, F_EN);
        check("carry.measure", 32'(measure_count), MK ? 32'd2 : 32'd0);
        expq = '{10'h100, 10'h100, 10'h100, 10'h1C0};
        if (MK) expq.push_back(10'h200);
        expq.push_back(10'h042);
        expq.push_back(10'h042);
        expq.push_back(10'h002);
        if (MK) expq.push_back(10'h201);
        check("carry.fill", 32'(fill_level), 32'(expq.size()));
        drain_expected("carry");

        // Fill to DEPTH with whole notes, then overflow
        do_reset();
        for (int i = 0; i < (MK ? 16 : 32); i++) send(6'd1, F_WN);
        check("full.fill",    32'(fill_level),      32'd32);
        check("full.measure", 32'(measure_count),   MK ? 32'd16 : 32'd0);
        check("full.head",    32'(evt_if.event_data), 32'h0C1);
        check("full.ovf0",    32'(overflow),        32'd0);
        send(6'd1, F_WN);
        check("ovf.fill",     32'(fill_level),      32'd32);
        check("ovf.overflow", 32'(overflow),        32'd1);
        check("ovf.dropped",  32'(dropped_count),   32'd1);
        check("ovf.measure",  32'(measure_count),   MK ? 32'd16 : 32'd0);
        // Same note with a simultaneous pop: one slot frees up
        @(negedge clk);
        nnr = 1'b1; tone = 6'd1; flags = F_WN; evt_if.event_ready = 1'b1;
        @(negedge clk);
        nnr = 1'b0; tone = 6'd0; flags = 8'd0; evt_if.event_ready = 1'b0;
        check("ovfpop.fill",    32'(fill_level),        MK ? 32'd31 : 32'd32);
        check("ovfpop.dropped", 32'(dropped_count),     MK ? 32'd2 : 32'd1);
        check("ovfpop.measure", 32'(measure_count),     MK ? 32'd16 : 32'd0);
        check("ovfpop.head",    32'(evt_if.event_data), MK ? 32'h200 : 32'h0C1);

        // Malformed strobes
        do_reset();
        send(6'd12, 8'h00);
        send(6'd12, F_QN | F_HN);
        check("bad.valid",    32'(evt_if.event_valid), 32'd0);
        check("bad.fill",     32'(fill_level),         32'd0);
        check("bad.dropped",  32'(dropped_count),      32'd2);
        check("bad.overflow", 32'(overflow),           32'd0);

        // Reset during a pop discards everything including the accumulator
        do_reset();
        for (int i = 0; i < 3; i++) send(6'd3, F_QN);
        send(6'd3, 8'h00);
        check("prerst.fill",    32'(fill_level),    32'd3);
        check("prerst.dropped", 32'(dropped_count), 32'd1);
        @(negedge clk);
        rst = 1'b1; evt_if.event_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; evt_if.event_ready = 1'b0;
        check("midrst.fill",    32'(fill_level),         32'd0);
        check("midrst.valid",   32'(evt_if.event_valid), 32'd0);
        check("midrst.dropped", 32'(dropped_count),      32'd0);
        check("midrst.measure", 32'(measure_count),      32'd0);
        send(6'd3, F_QN);
        check("postrst.data",    32'(evt_if.event_data), 32'h043);
        check("postrst.fill",    32'(fill_level),        32'd1);
        check("postrst.measure", 32'(measure_count),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/note_event_buffer.md
Name: note_event_buffer

Overview:
- Sits directly downstream of the duration detector and consumes its new_note_ready strobe, new_note_tone and eight one-hot duration flags.
- Packs each classified note or rest into a 10-bit event and tracks measure position in eighth-note units.
- Inserts a bar-line marker event at each measure boundary.
- Buffers events in a first-word-fall-through circular FIFO read by the score/display or UART stage through a valid/ready handshake.

Parameters:
- DEPTH, 32, FIFO entries; power of 2, minimum 4.
- EIGHTHS_PER_MEASURE, 8, measure length in eighth-note units (8 = 4/4); range 2..255.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- new_note_ready  input  1  one-cycle strobe: a classified note/rest is presented
- new_note_tone  input  6  tone index of that note (0 = silence)
- eighth_note, quarter_note, half_note, whole_note  input  1 each  note duration flags
- eighth_rest, quarter_rest, half_rest, whole_rest  input  1 each  rest duration flags
- event_ready  input  1  consumer accepts the head event this cycle
- event_valid  output  1  FIFO non-empty; event_data is valid
- event_data  output  10  head event
- fill_level  output  $clog2(DEPTH)+1  entries currently stored
- overflow  output  1  sticky: an input group was lost because the FIFO was full
- dropped_count  output  8  saturating count of discarded inputs
- measure_count  output  8  completed measures, wraps at 256

Behaviour:
- Clock and reset: clk_in only. rst_in is synchronous and active-high.
- Reset: FIFO emptied; read/write pointers = 0. event_valid=0, event_data=0, fill_level=0, overflow=0, dropped_count=0, measure_count=0. Measure accumulator = 0. Reset asserted mid-operation discards all stored and in-flight events.
- Note event encoding: [9]=0; [8]=rest; [7:6]=duration code (0 eighth, 1 quarter, 2 half, 3 whole); [5:0]=new_note_tone, passed through unmodified.
- Bar marker encoding: [9]=1; [8]=0; [7:0]=measure_count value before the increment, i.e. the index of the completed measure.
- Input qualification, sampled only when new_note_ready=1:
  - Exactly one of the 8 flags set: valid input.
  - Zero flags set, or more than one set: discard. dropped_count increments (saturating at 255). No FIFO or accumulator change.
- Measure accounting: length L is 1, 2, 4 or 8 eighths. sum = acc + L (9-bit). If sum >= EIGHTHS_PER_MEASURE, the group is note + bar marker, acc <= sum - EIGHTHS_PER_MEASURE, and measure_count increments. Otherwise the group is the note only and acc <= sum. A note crossing the barline is not split; the remainder carries into the next measure.
- Write: the whole group (1 or 2 entries) is written at the sampling edge. The note occupies the lower slot and the marker the next slot; both can be written in the same cycle.
- Space check: free = DEPTH - fill_level + pop, where pop = event_valid & event_ready in the same cycle. If the group needs more than free, the entire group is dropped: overflow <= 1, dropped_count increments, and acc and measure_count are unchanged.
- Read: FWFT. event_data shows the head entry combinationally from storage. pop advances the read pointer. event_ready while empty has no effect.
- Latency: an event accepted at edge N gives event_valid=1 after edge N if the FIFO was empty.
- Pointers wrap modulo DEPTH. fill_level = previous + pushes - pop, with simultaneous push and pop allowed at full or empty.

Optional Feature:
- Macro: MEASURE_MARKER_EN.
- Defined: bar markers are inserted as above, and acc and measure_count are active.
- Undefined: no markers are ever written, every valid group is 1 entry, measure_count is tied to 0, and the accumulator logic is absent.

Test Plan:
- Quarter note, tone 12, FIFO empty -> event_valid=1 one edge later, event_data=0x04C, fill_level=1; pulse event_ready -> event_valid=0.
- Eighth t5, eighth t5, quarter t7, half t9 (sum 8), event_ready=0 -> FIFO holds 0x005, 0x005, 0x047, 0x089, then 0x200; measure_count=1; fill_level=5.
- Three eighth rests, then whole rest -> after the whole rest, 0x1C0 is followed by marker 0x200; acc=3; a following quarter gives no marker until the sum reaches 8.
- DEPTH=32, event_ready=0, 16 whole notes t1 (note+marker each) -> fill_level=32. 17th whole note -> nothing written, overflow=1, dropped_count=1, measure_count=16. Repeat the 17th with event_ready=1 (free=1, needs 2) -> still dropped.
- new_note_ready with zero flags, then with quarter_note+half_note both set -> no events, dropped_count=2, overflow=0.
- Load 3 events, assert rst_in one cycle during a pop -> fill_level=0, event_valid=0, all counters 0; the next quarter t3 yields 0x043 with no leftover accumulator.
